mips_single_clk: RTL and testbench
==================================

# mips_single_clk

Single-cycle 32-bit MIPS subset processor with its own instruction and data memories. Each instruction is fetched, decoded, executed and retired in one clock. It is the top of the semiMIPS single-clock implementation. It runs a program preloaded into instruction memory and raises `fin` when it fetches the halt word.

## Interface
- No parameters. Sizes are fixed constants in the shared package.
- `clk` input 1: single clock. All state updates on the rising edge.
- `pcclr` input 1: reset, synchronous and active-high.
- `fin` output 1: program-finished flag. Registered and sticky until reset.
- Internal nets are part of the interface because benches probe them hierarchically:
  - `pcdata_out` (32): current PC.
  - `insmemins` (32): fetched instruction.
  - Instance `insmem` holds array `mem[0:255]` of 32-bit words.
  - Instance `datamem` holds array `mem[0:255]` of 32-bit words.

## Operation
- Supported instructions:
  - R-type (op 0x00): add, sub, and, or, slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A).
  - I-type: addi (0x08), lw (0x23), sw (0x2B), beq (0x04).
  - J-type: j (0x02).
  - HALT = 32'hFC00_0000 (op 0x3F).
- Any other opcode or funct executes as a nop: PC+4, no writes.
- Addressing is by byte, memories are indexed by word.
  - Instruction memory word = `mem[PC[9:2]]`.
  - Data memory word = `mem[addr[9:2]]`.
  - Example: byte address 4 is data `mem[1]`, 16 is `mem[4]`, 64 is `mem[16]`.
  - Address bits [1:0] and [31:10] are ignored; no alignment traps.
- Register file: 32×32, two asynchronous read ports, one synchronous write port.
  - `$0` always reads 0; writes to it are discarded.
- Write-back targets:
  - R-type writes `rd`.
  - addi and lw write `rt`.
- Arithmetic is 32-bit two's complement. Overflow wraps, no exception.
- Immediate extension:
  - addi, lw, sw and beq sign-extend imm16.
  - slt is a signed compare.
- Next PC:
  - Default: PC+4.
  - beq taken when rs==rt: PC+4+(sext(imm)<<2).
  - j: {PC+4[31:28], target26, 2'b00}.
- Instruction memory is read-only to the core and loaded externally; contents are X until loaded.
- Data memory is zero-initialised at time 0. It is not cleared by `pcclr`.

## Timing
- Reset (`pcclr`=1 at a rising edge):
  - PC ← 0, `fin` ← 0, all registers ← 0.
  - No register or memory writes occur in that cycle.
  - Takes effect identically mid-program.
- Fetch, register read, ALU, data read and next-PC logic are combinational within the cycle.
- Register write, data memory write (sw) and PC update commit together on the rising edge.
- Latency: one instruction per clock. A lw result is readable by the very next instruction; no hazards exist.
- HALT:
  - At the edge where the current instruction is HALT, `fin` ← 1 and PC holds.
  - While `fin`=1, PC and all state are frozen; no register or memory writes.
  - Only `pcclr` clears `fin`.
- Data memory reads `datamem.mem` combinationally. A sw followed by lw of the same address returns the stored value.

## Structure
- Shared package contents:
  - Opcode and funct constants.
  - HALT word.
  - ALU-control encodings.
  - Memory depth (256) and address slice width (8).
- Top level holds: PC register, `fin` register, control decode, ALU, next-PC mux, sign extender.
- Instance names are `insmem` and `datamem`; each owns a `mem` array. Submodules are combinational read with a synchronous-write port (tied off on `insmem`).
- One natural sub-module: `regfile` (32×32, 2R/1W, `$0` hard zero, synchronous clear).

## Test plan
- **Reset:** hold `pcclr`=1 for 2 edges, then 0 → `pcdata_out`=0 and `fin`=0; PC steps 0, 4, 8 on following edges.
- **ALU:**
  - Program: addi $1,$0,5; addi $2,$0,-3; add/sub/and/or/slt into $3..$7; sw each to byte addresses 4..20.
  - Expected: data `mem[1..5]` = 2, 8, 5&-3, 5|-3, 0.
  - slt $8,$2,$1 stored → 1.
- **beq:**
  - Taken branch skips an `addi $9,$9,1`; not-taken path executes it.
  - Stored $9: `mem[1]`=0 after the taken case, `mem[4]`=1 after the not-taken case.
  - Backward beq loop counting to 3 stores 3 to `mem[16]`.
- **lw/sw and j:**
  - sw 0xDEADBEEF to byte address 64, lw into $10, sw $10 to address 68 → `mem[17]`=0xDEADBEEF.
  - j over one instruction → skipped instruction has no effect.
- **HALT:** HALT at word 10 → `fin` rises at the edge after PC=40, PC stays 40, a following sw never executes.
- **Reset mid-run:**
  - Assert `pcclr` after `fin`, or mid-loop → PC=0, `fin`=0, registers 0, data memory retained.
  - The program reruns to the same results.

Source files
------------

// File: rtl/mips_single_clk_pkg.sv
// rtl/mips_single_clk_pkg.sv - shared constants and types for the single-clock MIPS subset core
// Contents: opcode/funct constants, HALT word, ALU-control encoding,
// memory geometry and the imm16 sign-extension helper.
package mips_single_clk_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_single_clk_mem.sv
// rtl/mips_single_clk_mem.sv - word memory with combinational read and synchronous write
// Ports: clk; we write enable; addr word index; wdata write word; rdata read word.
// The storage array is named mem so benches can load and inspect it.
module mips_single_clk_mem
    import mips_single_clk_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Power-up value only; the core reset deliberately leaves contents alone.
    logic [31:0] mem [0:MEM_DEPTH-1] = '{default: 32'h0};

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/mips_single_clk_regfile.sv
// rtl/mips_single_clk_regfile.sv - 32x32 register file, two async reads, one sync write
// Ports: clk; clr synchronous clear of all registers; we/wa/wd write port;
// ra1/ra2 read addresses; rd1/rd2 read data. Register 0 always reads zero.
module mips_single_clk_regfile (
    input  logic        clk,
    input  logic        clr,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/mips_single_clk.sv
// rtl/mips_single_clk.sv - single-cycle MIPS subset core with private instruction/data memories
// Ports: clk rising-edge clock; pcclr synchronous active-high reset;
// fin sticky program-finished flag, set when the HALT word is fetched.
// Probed nets: pcdata_out (current PC), insmemins (fetched instruction).
module mips_single_clk
    import mips_single_clk_pkg::*;
(
    input  logic clk,
    input  logic pcclr,
    output logic fin
);

    logic [31:0] pcdata_out;
    logic [31:0] insmemins;
    logic [31:0] pc_plus4, pc_next, imm_ext, rs_val, rt_val;
    logic [31:0] alu_b, alu_result, mem_rdata, wb_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic        reg_we, mem_we, alu_src, mem_to_reg, is_branch, is_jump, is_halt;
    logic        commit;
    alu_op_e     alu_op;

    assign opcode  = insmemins[31:26];
    assign rs      = insmemins[25:21];
    assign rt      = insmemins[20:16];
    assign rd      = insmemins[15:11];
    assign funct   = insmemins[5:0];
    assign imm_ext = sext16(insmemins[15:0]);
    assign is_halt = (insmemins == HALT_WORD);

    // Architectural writes happen only while running; a halted or resetting core is frozen.
    assign commit = !pcclr && !fin;

    mips_single_clk_mem insmem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pcdata_out[ADDR_W+1:2]),
        .wdata (32'h0),
        .rdata (insmemins)
    );

    mips_single_clk_regfile rf (
        .clk (clk),
        .clr (pcclr),
        .we  (reg_we && commit),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (wb_data),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    mips_single_clk_mem datamem (
        .clk   (clk),
        .we    (mem_we && commit),
        .addr  (alu_result[ADDR_W+1:2]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    // Control decode: anything unrecognised (including HALT) falls through as a nop.
    always_comb begin
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        wa         = rd;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
                    FN_AND: begin reg_we = 1'b1; alu_op = ALU_AND; end
                    FN_OR:  begin reg_we = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT: begin reg_we = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                alu_src = 1'b1;
                wa      = rt;
            end
            OP_LW: begin
                reg_we     = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                wa         = rt;
            end
            OP_SW: begin
                mem_we  = 1'b1;
                alu_src = 1'b1;
            end
            OP_BEQ:  is_branch = 1'b1;
            OP_J:    is_jump   = 1'b1;
            default: ;
        endcase
    end

    assign alu_b = alu_src ? imm_ext : rt_val;

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD: alu_result = rs_val + alu_b;
            ALU_SUB: alu_result = rs_val - alu_b;
            ALU_AND: alu_result = rs_val & alu_b;
            ALU_OR:  alu_result = rs_val | alu_b;
            ALU_SLT: alu_result = {31'b0, $signed(rs_val) < $signed(alu_b)};
            default: alu_result = 32'h0;
        endcase
    end

    assign wb_data  = mem_to_reg ? mem_rdata : alu_result;
    assign pc_plus4 = pcdata_out + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (is_jump) begin
            pc_next = {pc_plus4[31:28], insmemins[25:0], 2'b00};
        end else if (is_branch && (rs_val == rt_val)) begin
            pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
    end

    // HALT sets fin instead of advancing, so the PC stays on the HALT word.
    always_ff @(posedge clk) begin
        if (pcclr) begin
            pcdata_out <= 32'h0;
            fin        <= 1'b0;
        end else if (!fin) begin
            if (is_halt) begin
                fin <= 1'b1;
            end else begin
                pcdata_out <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_mips_single_clk.sv
// tb/tb_mips_single_clk.sv - self-checking bench for mips_single_clk with a data-memory scoreboard
module tb_mips_single_clk;

    logic clk   = 1'b0;
    logic pcclr = 1'b1;
    logic fin;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb   [$];
    logic [31:0] prog [$];

    localparam logic [31:0] HALT = 32'hFC00_0000;

    mips_single_clk dut (
        .clk   (clk),
        .pcclr (pcclr),
        .fin   (fin)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] a, b, c;
        a = rs; b = rt; c = rd;
        return {6'h00, a[4:0], b[4:0], c[4:0], 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [31:0] a, b, m;
        a = rs; b = rt; m = imm;
        return {op, a[4:0], b[4:0], m[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        logic [31:0] t;
        t = target;
        return {6'h02, t[25:0]};
    endfunction

    task automatic expect_word(input string tag, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, dut.datamem.mem[e.idx], e.val);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) begin
            if (i < prog.size()) dut.insmem.mem[i] = prog[i];
            else                 dut.insmem.mem[i] = HALT;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        pcclr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pcclr = 1'b0;
    endtask

    task automatic run_to_fin(input int budget, output int cycles);
        cycles = 0;
        while (fin !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("fin_reached", {31'b0, fin}, 32'd1);
    endtask

    task automatic push_beq_expect();
        expect_word("beq_taken_skip", 1, 32'd0);
        expect_word("beq_not_taken", 4, 32'd1);
        expect_word("beq_loop3", 16, 32'd3);
    endtask

    initial begin
        int cyc;

        // ALU program
        prog.delete();
        prog.push_back(enc_i(6'h08, 0, 1, 5));
        prog.push_back(enc_i(6'h08, 0, 2, -3));
        prog.push_back(enc_r(1, 2, 3, 6'h20));
        prog.push_back(enc_r(1, 2, 4, 6'h22));
        prog.push_back(enc_r(1, 2, 5, 6'h24));
        prog.push_back(enc_r(1, 2, 6, 6'h25));
        prog.push_back(enc_r(1, 2, 7, 6'h2A));
        prog.push_back(enc_r(2, 1, 8, 6'h2A));
        prog.push_back(enc_r(1, 2, 3, 6'h27));
        prog.push_back(enc_i(6'h2B, 0, 3, 4));
        prog.push_back(enc_i(6'h2B, 0, 4, 8));
        prog.push_back(enc_i(6'h2B, 0, 5, 12));
        prog.push_back(enc_i(6'h2B, 0, 6, 16));
        prog.push_back(enc_i(6'h2B, 0, 7, 20));
        prog.push_back(enc_i(6'h2B, 0, 8, 24));
        prog.push_back(HALT);
        load_prog();

        do_reset();
        check("rst_pc", dut.pcdata_out, 32'd0);
        check("rst_fin", {31'b0, fin}, 32'd0);
        @(negedge clk);
        check("pc_step4", dut.pcdata_out, 32'd4);
        @(negedge clk);
        check("pc_step8", dut.pcdata_out, 32'd8);
        check("fetch_word2", dut.insmemins, prog[2]);

        expect_word("alu_add", 1, 32'd2);
        expect_word("alu_sub_nop_kept", 2, 32'd8);
        expect_word("alu_and", 3, 32'd5);
        expect_word("alu_or", 4, 32'hFFFF_FFFD);
        expect_word("alu_slt0", 5, 32'd0);
        expect_word("alu_slt1", 6, 32'd1);
        do_reset();
        run_to_fin(200, cyc);
        drain();

        // beq program: forward taken/not-taken, then a backward counting loop
        prog.delete();
        prog.push_back(enc_i(6'h08, 0, 1, 1));
        prog.push_back(enc_i(6'h08, 0, 2, 1));
        prog.push_back(enc_i(6'h04, 1, 2, 1));
        prog.push_back(enc_i(6'h08, 9, 9, 1));
        prog.push_back(enc_i(6'h2B, 0, 9, 4));
        prog.push_back(enc_i(6'h04, 1, 0, 1));
        prog.push_back(enc_i(6'h08, 9, 9, 1));
        prog.push_back(enc_i(6'h2B, 0, 9, 16));
        prog.push_back(enc_i(6'h08, 0, 10, 0));
        prog.push_back(enc_i(6'h08, 0, 11, 3));
        prog.push_back(enc_i(6'h08, 10, 10, 1));
        prog.push_back(enc_r(10, 11, 12, 6'h2A));
        prog.push_back(enc_i(6'h04, 12, 1, -3));
        prog.push_back(enc_i(6'h2B, 0, 10, 64));
        prog.push_back(HALT);
        load_prog();
        push_beq_expect();
        do_reset();
        run_to_fin(200, cyc);
        drain();

        // Rerun, reset mid-loop, then rerun to completion
        do_reset();
        repeat (12) @(negedge clk);
        pcclr = 1'b1;
        @(negedge clk);
        check("mid_rst_pc", dut.pcdata_out, 32'd0);
        check("mid_rst_fin", {31'b0, fin}, 32'd0);
        check("mid_rst_r10", dut.rf.regs[10], 32'd0);
        check("mid_rst_r1", dut.rf.regs[1], 32'd0);
        check("mid_rst_mem_kept", dut.datamem.mem[16], 32'd3);
        pcclr = 1'b0;
        push_beq_expect();
        run_to_fin(200, cyc);
        drain();

        // lw/sw, jump, address bit masking and $0 write discard
        prog.delete();
        prog.push_back(enc_i(6'h08, 0, 1, 32'hDEAE));
        for (int i = 0; i < 16; i++) prog.push_back(enc_r(1, 1, 1, 6'h20));
        prog.push_back(enc_i(6'h08, 1, 1, 32'hBEEF));
        prog.push_back(enc_i(6'h2B, 0, 1, 64));
        prog.push_back(enc_i(6'h23, 0, 10, 64));
        prog.push_back(enc_i(6'h2B, 0, 10, 68));
        prog.push_back(enc_j(23));
        prog.push_back(enc_i(6'h08, 0, 10, 7));
        prog.push_back(enc_i(6'h2B, 0, 10, 72));
        prog.push_back(enc_i(6'h08, 0, 14, 80));
        prog.push_back(enc_i(6'h2B, 0, 14, 32'h0451));
        prog.push_back(enc_i(6'h2B, 0, 14, 84));
        prog.push_back(enc_i(6'h08, 0, 0, 5));
        prog.push_back(enc_i(6'h2B, 0, 0, 84));
        prog.push_back(HALT);
        load_prog();
        expect_word("sw_deadbeef", 16, 32'hDEAD_BEEF);
        expect_word("lw_then_sw", 17, 32'hDEAD_BEEF);
        expect_word("j_skip", 18, 32'hDEAD_BEEF);
        expect_word("addr_bits_ignored", 20, 32'd80);
        expect_word("r0_hard_zero", 21, 32'd0);
        do_reset();
        run_to_fin(200, cyc);
        drain();

        // HALT at word 10 with a store behind it
        prog.delete();
        prog.push_back(enc_i(6'h08, 0, 1, 9));
        for (int i = 0; i < 9; i++) prog.push_back(enc_i(6'h08, 1, 1, 1));
        prog.push_back(HALT);
        prog.push_back(enc_i(6'h2B, 0, 1, 128));
        load_prog();
        expect_word("no_sw_after_halt", 32, 32'd0);
        do_reset();
        run_to_fin(100, cyc);
        check("halt_cycles", cyc, 32'd11);
        check("halt_pc", dut.pcdata_out, 32'd40);
        repeat (5) @(negedge clk);
        check("halt_pc_hold", dut.pcdata_out, 32'd40);
        check("halt_fin_sticky", {31'b0, fin}, 32'd1);
        check("halt_r1", dut.rf.regs[1], 32'd18);
        drain();

        // Reset after fin, then rerun
        pcclr = 1'b1;
        @(negedge clk);
        check("post_fin_rst_pc", dut.pcdata_out, 32'd0);
        check("post_fin_rst_fin", {31'b0, fin}, 32'd0);
        check("post_fin_rst_r1", dut.rf.regs[1], 32'd0);
        pcclr = 1'b0;
        expect_word("rerun_no_sw", 32, 32'd0);
        run_to_fin(100, cyc);
        check("rerun_halt_cycles", cyc, 32'd11);
        check("rerun_halt_pc", dut.pcdata_out, 32'd40);
        check("rerun_r1", dut.rf.regs[1], 32'd18);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
